perf_counter_bank: RTL and testbench
====================================

Name: perf_counter_bank

Overview:
- Parametrised event-statistics unit for the 5-stage pipelined CPU.
- Generalises the fixed cycle/jump counters in `main` into NUM_CH independent event counters.
- Adds halt-freeze, synchronous clear, snapshot shadow registers, sticky overflow flags and registered read-back.
- Sits beside the pipeline. WB drives the halt input; IF/EX/MEM drive the event strobes (cycle, jump/branch taken, load-use stall, syscall).

Parameters:
- NUM_CH, 4, number of event channels. Channel 0 is the cycle counter by convention (event[0] tied high).
- CNT_W, 32, width of each counter and shadow register.
- SEL_W, 2, width of the read select. Must satisfy 2**SEL_W >= NUM_CH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- halt  input  1  halt strobe from WB; freezes counting.
- clr  input  1  synchronous clear of counters, overflow flags and freeze.
- event  input  NUM_CH  per-channel increment strobe; +1 per cycle while asserted.
- snap  input  1  copy all live counters into the shadow registers.
- sel  input  SEL_W  shadow channel select for read-back.
- rd_data  output  CNT_W  registered shadow[sel].
- ovf  output  NUM_CH  sticky per-channel overflow flags.
- frozen  output  1  high while in state FROZEN.

Behaviour:
- Reset (rst=1 at a clock edge): all counters, shadows, ovf and rd_data become 0; state becomes RUN; frozen=0. rst has priority over every other input.
- State machine has two states, RUN and FROZEN.
  - RUN -> FROZEN when halt=1 and clr=0.
  - FROZEN -> RUN only on clr=1 (or rst).
  - halt=1 while already in FROZEN has no effect.
- Counting:
  - In RUN, counter[i] <= counter[i] + event[i] every cycle.
  - In the cycle that halt is sampled, that cycle's events still count. Freezing takes effect from the next cycle.
  - In FROZEN, counters hold.
- Clear:
  - clr=1 sets all counters and ovf to 0 and forces RUN.
  - clr overrides event and halt in the same cycle; no increments occur.
  - Shadow registers are not cleared by clr.
- Overflow: when counter[i] is all-ones and event[i]=1 (in RUN), the counter wraps to 0 and ovf[i] is set. ovf[i] stays set until clr or rst.
- Snapshot:
  - snap=1 sets shadow[i] <= counter[i], using the register value before this cycle's increment or clear.
  - snap together with clr captures the pre-clear values.
  - snap works in both states.
- Read-back:
  - rd_data <= shadow[sel], one-cycle latency.
  - sel >= NUM_CH returns 0.
  - A snap and a read of the same channel in the same cycle return the old shadow value. The new value appears one cycle later.
- Width rules: counters are unsigned modulo 2**CNT_W; no sign extension anywhere.
- Reset mid-operation: rst during FROZEN or during snap aborts both and applies the reset values.

Optional Feature:
- Macro: PERF_SATURATE_EN.
- Defined: a counter at all-ones with event=1 holds at all-ones instead of wrapping. ovf[i] is still set on the first saturating increment.
- Undefined: wrap-to-0 behaviour as above.
- Both builds have the same ports and latency.

Decomposition:
- Package perf_pkg holds:
  - state encoding constants (ST_RUN=1'b0, ST_FROZEN=1'b1);
  - default CNT_W and NUM_CH;
  - the all-ones compare constant helper.
- Sub-module perf_counter_ch, instantiated NUM_CH times via generate. It holds one counter, its overflow flag and its shadow register, with inputs count_en, clr, snap. Saturate logic sits inside it under PERF_SATURATE_EN.
- The top level owns the FSM, the read mux and the rd_data register.

Test Plan:
- Reset and count:
  - Stimulus: rst for 2 cycles, then event=4'b0001 for 10 cycles, snap, sel=0.
  - Required: rd_data=10 one cycle after the select is sampled; ovf=0; frozen=0.
- Halt freeze:
  - Stimulus: event=4'b0011 for 5 cycles, halt=1 in cycle 5, events continue 5 more cycles, snap, sel=1.
  - Required: rd_data=5; frozen=1 from cycle 6; counters unchanged after a further 20 cycles.
- Overflow (CNT_W=4):
  - Stimulus: event[2]=1 for 17 cycles, snap, sel=2.
  - Required without macro: rd_data=1, ovf[2]=1.
  - Required with PERF_SATURATE_EN: rd_data=15, ovf[2]=1.
- Clear with snap:
  - Stimulus: counter[0]=7; clr=1 and snap=1 in the same cycle with event[0]=1.
  - Required: shadow[0]=7; counter[0]=0 next cycle; ovf cleared; frozen=0.
- Read edge cases:
  - Stimulus: sel=3 with NUM_CH=3.
  - Required: rd_data=0.
  - Stimulus: snap and sel=0 in the same cycle.
  - Required: old shadow value returned first, new value the following cycle.
- Mid-operation reset:
  - Stimulus: in FROZEN with ovf=4'b0100, assert rst together with clr=0 and snap=1.
  - Required: all outputs 0 next cycle; state RUN.

Source files
------------

// File: rtl/perf_pkg.sv
// perf_pkg: shared state encoding, default sizes and all-ones helper for the perf counter bank
package perf_pkg;
  typedef enum logic {ST_RUN = 1'b0, ST_FROZEN = 1'b1} state_e;
  localparam int DEF_CNT_W = 32;
  localparam int DEF_NUM_CH = 4;
  localparam int MAX_W = 64;
  // all-ones mask of width w (w <= MAX_W), right-aligned in a MAX_W vector
  function automatic logic [MAX_W-1:0] all_ones(input int unsigned w);
    return {MAX_W{1'b1}} >> (MAX_W - w);
  endfunction
endpackage

// File: rtl/perf_counter_ch.sv
// perf_counter_ch: one event counter with sticky overflow flag and snapshot shadow
// Ports: clk, rst (sync, active-high); count_en_i increments by one; clr_i zeroes counter and
// overflow; snap_i copies the pre-update counter into shadow_o; ovf_o sticky overflow flag.
// PERF_SATURATE_EN: when defined the counter holds at all-ones instead of wrapping.
module perf_counter_ch
  import perf_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             count_en_i,
  input  logic             clr_i,
  input  logic             snap_i,
  output logic [CNT_W-1:0] shadow_o,
  output logic             ovf_o
);
  localparam logic [CNT_W-1:0] ONES = CNT_W'(all_ones(CNT_W));
  logic [CNT_W-1:0] cnt_q, cnt_d, shadow_q, shadow_d;
  logic             ovf_q, ovf_d, hit;
  assign hit = count_en_i && (cnt_q == ONES);
  always_comb begin
`ifdef PERF_SATURATE_EN
    cnt_d = clr_i ? '0 : (count_en_i && !hit) ? cnt_q + 1'b1 : cnt_q;
`else
    cnt_d = clr_i ? '0 : count_en_i ? cnt_q + 1'b1 : cnt_q;
`endif
    ovf_d = clr_i ? 1'b0 : ovf_q | hit;
    shadow_d = snap_i ? cnt_q : shadow_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
      shadow_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      shadow_q <= shadow_d;
    end
  end
  assign shadow_o = shadow_q;
  assign ovf_o = ovf_q;
endmodule

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: NUM_CH event counters with halt-freeze, clear, snapshot and registered read-back
// Ports: clk, rst (sync, active-high); halt_i freezes counting; clr_i clears counters/ovf and
// unfreezes; event_i per-channel increment strobes; snap_i captures counters into shadows;
// sel_i shadow select; rd_data_o registered shadow[sel_i]; ovf_o sticky overflow; frozen_o state.
// PERF_SATURATE_EN: counters saturate at all-ones instead of wrapping.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int SEL_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt_i,
  input  logic              clr_i,
  input  logic [NUM_CH-1:0] event_i,
  input  logic              snap_i,
  input  logic [SEL_W-1:0]  sel_i,
  output logic [CNT_W-1:0]  rd_data_o,
  output logic [NUM_CH-1:0] ovf_o,
  output logic              frozen_o
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  // padded to the full select range so out-of-range selects read zero
  logic [CNT_W-1:0] shadow [2**SEL_W];
  always_comb begin
    state_d = clr_i ? ST_RUN : halt_i ? ST_FROZEN : state_q;
    rd_data_d = shadow[sel_i];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      rd_data_q <= rd_data_d;
    end
  end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    perf_counter_ch #(.CNT_W(CNT_W)) u_ch (
      .clk        (clk),
      .rst        (rst),
      .count_en_i (event_i[i] && (state_q == ST_RUN)),
      .clr_i      (clr_i),
      .snap_i     (snap_i),
      .shadow_o   (shadow[i]),
      .ovf_o      (ovf_o[i])
    );
  end
  for (genvar i = NUM_CH; i < 2**SEL_W; i++) begin : g_pad
    assign shadow[i] = '0;
  end
  assign rd_data_o = rd_data_q;
  assign frozen_o = (state_q == ST_FROZEN);
endmodule

// File: tb/tb_perf_counter_bank.sv
// tb_perf_counter_bank: directed self-checking bench for perf_counter_bank (3 channels, 4-bit counters)
module tb_perf_counter_bank;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       halt = 1'b0;
  logic       clr = 1'b0;
  logic [2:0] ev = '0;
  logic       snap = 1'b0;
  logic [1:0] sel = '0;
  logic [3:0] rd_data;
  logic [2:0] ovf;
  logic       frozen;
  int         n_vec = 0;
  int         n_err = 0;

  perf_counter_bank #(.NUM_CH(3), .CNT_W(4), .SEL_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .halt_i    (halt),
    .clr_i     (clr),
    .event_i   (ev),
    .snap_i    (snap),
    .sel_i     (sel),
    .rd_data_o (rd_data),
    .ovf_o     (ovf),
    .frozen_o  (frozen)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    tick(2);
    chk("rst_rd", rd_data, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_frozen", frozen, 0);
    rst = 1'b0;
    ev = 3'b001;
    tick(10);
    ev = '0;
    snap = 1'b1;
    sel = 2'd0;
    tick();
    chk("snap_read_old", rd_data, 0);
    snap = 1'b0;
    tick();
    chk("count10", rd_data, 10);
    chk("count_ovf", ovf, 0);
    chk("count_frozen", frozen, 0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    ev = 3'b011;
    tick(4);
    chk("pre_halt_frozen", frozen, 0);
    halt = 1'b1;
    tick();
    chk("halt_frozen", frozen, 1);
    halt = 1'b0;
    tick(25);
    chk("stay_frozen", frozen, 1);
    snap = 1'b1;
    sel = 2'd1;
    tick();
    snap = 1'b0;
    tick();
    chk("halt_ch1", rd_data, 5);
    sel = 2'd0;
    tick();
    chk("halt_ch0", rd_data, 5);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    ev = 3'b001;
    tick(7);
    clr = 1'b1;
    snap = 1'b1;
    tick();
    chk("clr_unfreeze", frozen, 0);
    clr = 1'b0;
    snap = 1'b0;
    ev = '0;
    tick();
    chk("clr_snap_pre", rd_data, 7);
    snap = 1'b1;
    tick();
    snap = 1'b0;
    tick();
    chk("clr_cnt_zero", rd_data, 0);
    chk("clr_ovf", ovf, 0);
    ev = 3'b100;
    tick(17);
    ev = '0;
    chk("ovf_flag", ovf, 3'b100);
    snap = 1'b1;
    sel = 2'd2;
    tick();
    snap = 1'b0;
    tick();
`ifdef PERF_SATURATE_EN
    chk("ovf_value", rd_data, 15);
`else
    chk("ovf_value", rd_data, 1);
`endif
    sel = 2'd3;
    tick();
    chk("sel_oob", rd_data, 0);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("pre_rst_frozen", frozen, 1);
    rst = 1'b1;
    snap = 1'b1;
    sel = 2'd2;
    tick();
    chk("midrst_rd", rd_data, 0);
    chk("midrst_ovf", ovf, 0);
    chk("midrst_frozen", frozen, 0);
    rst = 1'b0;
    snap = 1'b0;
    sel = 2'd0;
    ev = 3'b001;
    tick(3);
    ev = '0;
    snap = 1'b1;
    tick();
    snap = 1'b0;
    tick();
    chk("post_rst_count", rd_data, 3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
